// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative shifts and multiply,
// with valid/ready on both sides and result/flags registered on entry to DONE.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       AluOpCode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow,
  output logic             IllegalOp
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_AND = 4'h0, OP_OR  = 4'h1, OP_XOR = 4'h2, OP_NOR  = 4'h3,
                         OP_ADD = 4'h4, OP_SUB = 4'h5, OP_SLT = 4'h6, OP_SLTU = 4'h7,
                         OP_SLL = 4'h8, OP_SRL = 4'h9, OP_SRA = 4'hA, OP_MUL  = 4'hB;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, ill_q, ill_d;

  logic             sub, iter_op, comb_c, comb_v, comb_ill;
  logic [WIDTH-1:0] b_eff, comb_res, acc_step;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt_in;

  assign shamt_in = B[SHW-1:0];
  assign iter_op  = (AluOpCode[3:2] == 2'b10);

  // Single-cycle datapath, evaluated straight off the input operands.
  always_comb begin
    sub      = (AluOpCode == OP_SUB);
    b_eff    = sub ? ~B : B;
    sum      = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    comb_res = '0;
    comb_c   = 1'b0;
    comb_v   = 1'b0;
    comb_ill = 1'b0;
    case (AluOpCode)
      OP_AND:         comb_res = A & B;
      OP_OR:          comb_res = A | B;
      OP_XOR:         comb_res = A ^ B;
      OP_NOR:         comb_res = ~(A | B);
      OP_ADD, OP_SUB: begin
        comb_res = sum[WIDTH-1:0];
        comb_c   = sum[WIDTH];
        comb_v   = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:         comb_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU:        comb_res = {{(WIDTH-1){1'b0}}, A < B};
      default:        comb_ill = ~iter_op;
    endcase
  end

  // One iteration step; a zero shift amount still burns one cycle but leaves acc alone.
  always_comb begin
    acc_step = acc_q;
    case (op_q)
      OP_SLL:  if (b_q[SHW-1:0] != '0) acc_step = acc_q << 1;
      OP_SRL:  if (b_q[SHW-1:0] != '0) acc_step = acc_q >> 1;
      OP_SRA:  if (b_q[SHW-1:0] != '0) acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: acc_step = acc_q + (b_q[0] ? a_q : '0);
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (iter_op) begin
          state_d = BUSY;
          a_d     = A;
          b_d     = B;
          op_d    = AluOpCode;
          if (AluOpCode == OP_MUL) begin
            acc_d = '0;
            cnt_d = CW'(WIDTH);
          end else begin
            acc_d = A;
            cnt_d = (shamt_in == '0) ? CW'(1) : {1'b0, shamt_in};
          end
        end else begin
          state_d = DONE;
          res_d   = comb_res;
          zero_d  = (comb_res == '0);
          carry_d = comb_c;
          ovf_d   = comb_v;
          ill_d   = comb_ill;
        end
      end
      BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          res_d   = acc_step;
          zero_d  = (acc_step == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Result    = res_q;
  assign Zero      = zero_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;
  assign IllegalOp = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus random traffic with random
// back-pressure, all checked every cycle against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, Result;
  logic [3:0]   AluOpCode;
  logic         Zero, Carry, Overflow, IllegalOp;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .AluOpCode(AluOpCode), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Zero(Zero), .Carry(Carry), .Overflow(Overflow), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int bp_mode = 1;           // 0: hold off, 1: always ready, 2: random
  int to_cnt = 0, to_seen = 0;

  // Literal expectations attached to the next accepted operation.
  logic         lit_en;
  logic [W-1:0] lit_res;
  logic [3:0]   lit_flg;     // {Zero, Carry, Overflow, IllegalOp}
  int           lit_lat;

  always @(posedge clk) begin
    #1;
    out_ready = (bp_mode == 2) ? 1'($urandom_range(0, 1)) : (bp_mode == 1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic c, output logic v,
                                output logic il, output int lat);
    longint sa, sb, s;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    r = '0; c = 1'b0; v = 1'b0; il = 1'b0; lat = 1;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a ^ b;
      4'h3: r = ~(a | b);
      4'h4: begin r = a + b; c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF; s = sa + sb; v = (s > SMAX) || (s < SMIN); end
      4'h5: begin r = a - b; c = (a >= b); s = sa - sb; v = (s > SMAX) || (s < SMIN); end
      4'h6: r = (sa < sb) ? 32'd1 : 32'd0;
      4'h7: r = (a < b) ? 32'd1 : 32'd0;
      4'h8: begin r = a << sh; lat = ((sh == 0) ? 1 : sh) + 1; end
      4'h9: begin r = a >> sh; lat = ((sh == 0) ? 1 : sh) + 1; end
      4'hA: begin r = 32'($signed(a) >>> sh); lat = ((sh == 0) ? 1 : sh) + 1; end
      4'hB: begin r = 32'(64'(a) * 64'(b)); lat = W + 1; end
      default: il = 1'b1;
    endcase
  endfunction

  // Reference state: what the outputs must look like after each edge.
  logic [W-1:0] m_res = '0, st_res = '0, trk_res = '0;
  logic         m_z = 0, m_c = 0, m_v = 0, m_il = 0, st_c = 0, st_v = 0, st_il = 0;
  logic [3:0]   trk_flg = '0;
  bit           m_busy = 0, m_done = 0, trk = 0;
  int           m_rem = 0, trk_cnt = 0, trk_lat = 0;

  always @(negedge clk) begin
    int lat;
    if (rst) begin
      m_busy = 0; m_done = 0; trk = 0;
      m_res = '0; m_z = 0; m_c = 0; m_v = 0; m_il = 0;
    end
    if (trk) trk_cnt++;
    chk("in_ready",  64'(in_ready),  64'(!(m_busy || m_done)));
    chk("out_valid", 64'(out_valid), 64'(m_done));
    chk("result",    64'(Result),    64'(m_res));
    chk("flags",     64'({Zero, Carry, Overflow, IllegalOp}), 64'({m_z, m_c, m_v, m_il}));
    if (trk && out_valid) begin
      chk("lit_latency", 64'(trk_cnt), 64'(trk_lat));
      chk("lit_result",  64'(Result),  64'(trk_res));
      chk("lit_flags",   64'({Zero, Carry, Overflow, IllegalOp}), 64'(trk_flg));
      trk = 0;
    end
    if (to_cnt != to_seen) begin
      chk("handshake_timeout", 64'(to_cnt), 64'(to_seen));
      to_seen = to_cnt;
    end
    if (!rst) begin
      if (m_done) begin
        if (out_ready) m_done = 0;
      end else if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1;
          m_res = st_res; m_z = (st_res == '0); m_c = st_c; m_v = st_v; m_il = st_il;
        end
      end else if (in_valid) begin
        model(AluOpCode, A, B, st_res, st_c, st_v, st_il, lat);
        if (lit_en) begin
          chk("model_result",  64'(st_res), 64'(lit_res));
          chk("model_latency", 64'(lat),    64'(lit_lat));
          trk = 1; trk_cnt = 0; trk_res = lit_res; trk_flg = lit_flg; trk_lat = lit_lat;
        end
        m_rem = lat - 1;
        if (m_rem == 0) begin
          m_done = 1;
          m_res = st_res; m_z = (st_res == '0); m_c = st_c; m_v = st_v; m_il = st_il;
        end else begin
          m_busy = 1;
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit le = 0, input logic [W-1:0] lr = '0,
                      input logic [3:0] lf = '0, input int ll = 0);
    bit ok;
    int n;
    A = a; B = b; AluOpCode = op; in_valid = 1'b1;
    lit_en = le; lit_res = lr; lit_flg = lf; lit_lat = ll;
    n = 0;
    do begin
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 400);
    if (!ok) to_cnt++;
    in_valid = 1'b0;
    lit_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) to_cnt++;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; AluOpCode = '0;
    lit_en = 1'b0; lit_res = '0; lit_flg = '0; lit_lat = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset lands mid-multiply: the operation must vanish without output.
    send(4'hB, 32'd5, 32'd7);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(4'h4, 32'd1, 32'd1, 1'b1, 32'd2, 4'b0000, 1);

    send(4'h4, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0,         4'b1100, 1);
    send(4'h4, 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h8000_0000, 4'b0010, 1);
    send(4'h5, 32'd3,         32'd5, 1'b1, 32'hFFFF_FFFE, 4'b0000, 1);
    send(4'h6, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1,         4'b0000, 1);
    send(4'h7, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0,         4'b1000, 1);
    send(4'hA, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000, 4'b0000, 5);
    send(4'h8, 32'h0000_1234, 32'd0, 1'b1, 32'h0000_1234, 4'b0000, 2);
    send(4'h9, 32'h8000_0000, 32'd31, 1'b1, 32'd1,        4'b0000, 32);
    send(4'hB, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0, 4'b1000, 33);
    send(4'hB, 32'd12,        32'd11, 1'b1, 32'd132,      4'b0000, 33);

    // Back-pressure: the OR result must hold while a waiting XOR is ignored.
    wait_idle();
    bp_mode = 0;
    send(4'h1, 32'h0000_00F0, 32'h0000_000F, 1'b1, 32'h0000_00FF, 4'b0000, 1);
    fork
      send(4'h2, 32'h0000_00FF, 32'h0000_000F, 1'b1, 32'h0000_00F0, 4'b0000, 1);
      begin
        repeat (10) @(posedge clk);
        #1 bp_mode = 1;
      end
    join
    send(4'hE, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'h0, 4'b1001, 1);

    bp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(4'($urandom_range(0, 15)), pick(), pick());
    end
    bp_mode = 1;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
